miller_rx_ctrl: RTL and testbench
=================================

// Module: miller_rx_ctrl
// PURPOSE
//  Receive-side sequencer for the Miller decoder. Arms the decoder (drives its enable),
//  waits for bit sync, hunts for a sync word, reads a length byte, then delivers payload
//  bytes and a completion/error status per frame. Sits between the decoder and the packet layer.
// PARAMETERS
//  SYNC_WORD     16'hD391  sync pattern, MSB first; matched over the last SW_BITS bits
//  SW_BITS       16        sync word length in bits (1..16)
//  HUNT_TIMEOUT  1024      max decoded bits in SYNC state before timeout error
//  MAX_LEN       64        max legal payload length in bytes (1..255)
// PORTS
//  clk2x       in   1   2x bit-rate clock, same clock as the decoder
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   pulse: arm receiver (ignored unless busy=0)
//  abort       in   1   pulse: drop current frame, return to IDLE, no status pulse
//  dec_dout    in   1   decoder data out (Z while dec_enable=0)
//  dec_error   in   1   decoder sync-loss flag (Z while dec_enable=0)
//  dec_enable  out  1   decoder enable
//  byte_data   out  8   payload byte, MSB received first
//  byte_valid  out  1   1-cycle strobe, byte_data valid
//  frame_len   out  8   length byte of current frame, valid from LEN exit until next start
//  frame_done  out  1   1-cycle strobe, frame completed ok
//  frame_err   out  1   1-cycle strobe, frame aborted by error
//  err_code    out  2   0 none, 1 sync lost, 2 hunt timeout, 3 bad length; held until next start
//  busy        out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (dec_enable=0, byte_data=0, err_code=0).
//  dec_dout/dec_error ignored (treated as 0 / 1) whenever dec_enable=0; no X/Z propagation.
//  Bit strobe: 1-bit phase toggles each clk2x while in LOCK..PAYLOAD; reset to 0 on LOCK entry;
//   a bit is sampled when phase=1 (one decoded bit per 2 clk2x).
//  FSM:
//   IDLE    - start -> LOCK; clears err_code, frame_len; dec_enable=1 in all states but IDLE.
//   LOCK    - wait dec_error=0 for 2 consecutive clk2x -> SYNC.
//   SYNC    - shift bits into SW_BITS shift reg; match -> LEN; bit counter hits HUNT_TIMEOUT
//             -> ERR(code 2). Shift reg cleared on entry.
//   LEN     - collect 8 bits -> frame_len; len=0 -> DONE; len>MAX_LEN -> ERR(code 3);
//             else -> PAYLOAD.
//   PAYLOAD - every 8 bits: byte_valid pulse same cycle the 8th bit is sampled; byte count
//             reaches frame_len -> DONE.
//   DONE    - frame_done=1 for 1 cycle -> IDLE (dec_enable drops next cycle).
//   ERR     - frame_err=1 for 1 cycle, err_code latched -> IDLE.
//  Sync loss: dec_error=1 in SYNC/LEN/PAYLOAD -> ERR(code 1); takes priority over a bit
//   sampled in the same cycle (that bit discarded, no byte_valid).
//  Latency: last payload bit sampled at cycle N -> byte_valid at N, frame_done at N+1.
//  abort: highest priority in any state -> IDLE next cycle; pending strobes suppressed.
//  start while busy: ignored. start and abort same cycle in IDLE: abort wins (stay IDLE).
//  Counters: bit counter 4 bits for byte assembly (wraps 7->0), hunt counter
//   clog2(HUNT_TIMEOUT+1) bits, saturating; byte counter 8 bits, no wrap (len<=255).
//  rst_n asserted mid-frame: immediate return to reset values, no strobes.
// STRUCTURE
//  Shared header rf_codec_defs.vh: FSM state encodings, ERR_* codes, default SYNC_WORD.
//  Sub-module miller_rx_deser: bit strobe phase, 8-bit shifter, bit count, byte_ready.
//  Top holds FSM, sync matcher, hunt/byte counters and status registers.
// TESTING
//  1 start, sync then 0xD391, len 0x03, bytes A5 3C FF -> three byte_valid with A5,3C,FF; frame_done; err_code 0.
//  2 start, sync, 1024 random bits without SYNC_WORD -> frame_err, err_code=2, busy=0 next cycle.
//  3 sync word, len 0x41 (MAX_LEN=64) -> frame_err, err_code=3, no byte_valid.
//  4 dec_error=1 mid 2nd payload byte -> frame_err, err_code=1, only 1 byte_valid.
//  5 len 0x00 -> frame_done 1 cycle after last len bit, no byte_valid; abort mid-payload -> IDLE, no strobes.
//  6 rst_n low mid-payload, dec_* driven Z while disabled -> all outputs 0, no X on outputs.

Source files
------------

// File: rtl/miller_rx_ctrl_pkg.sv
// Shared definitions for the Miller receive sequencer: FSM states, error codes
// and the default sync pattern.
package miller_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOCK    = 3'd1,
        ST_SYNC    = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_SYNC_LOST    = 2'd1;
    localparam logic [1:0] ERR_HUNT_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BAD_LEN      = 2'd3;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hD391;

    // Selects the low 'bits' positions of the 16-bit sync shift register.
    function automatic logic [15:0] sw_mask(input int bits);
        return 16'hFFFF >> (16 - bits);
    endfunction

endpackage

// File: rtl/miller_rx_ctrl_deser.sv
// Bit strobe generator and byte assembler: one decoded bit every second clk2x,
// MSB-first shifting, byte_ready on the cycle the 8th bit is sampled.
module miller_rx_ctrl_deser (
    input  logic       clk2x,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear_cnt,
    input  logic       shift_en,
    input  logic       din,
    output logic       strobe,
    output logic [7:0] byte_data,
    output logic       byte_ready
);

    logic       phase;
    logic [6:0] sh;
    logic [3:0] cnt;

    assign strobe     = run & phase;
    assign byte_data  = {sh, din};
    assign byte_ready = strobe & shift_en & (cnt == 4'd7);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            phase <= run ? ~phase : 1'b0;
            if (clear_cnt) begin
                sh  <= '0;
                cnt <= '0;
            end else if (strobe && shift_en) begin
                sh  <= {sh[5:0], din};
                cnt <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/miller_rx_ctrl.sv
// Receive-side sequencer for the Miller decoder: lock, sync-word hunt, length
// byte, payload delivery and per-frame completion/error status.
module miller_rx_ctrl
    import miller_rx_ctrl_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD    = DEF_SYNC_WORD,
    parameter int          SW_BITS      = 16,
    parameter int          HUNT_TIMEOUT = 1024,
    parameter int          MAX_LEN      = 64
) (
    input  logic       clk2x,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dec_dout,
    input  logic       dec_error,
    output logic       dec_enable,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic [7:0] frame_len,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int          HW      = $clog2(HUNT_TIMEOUT + 1);
    localparam logic [15:0] SW_MASK = sw_mask(SW_BITS);

    state_t      state, state_next;
    logic [1:0]  err_next;
    logic        dout_s, err_s;
    logic        run, clear_cnt, shift_en, strobe, byte_ready;
    logic [7:0]  des_byte;
    logic        lock_prev;
    logic [15:0] sreg, sreg_next;
    logic        sync_bit, sw_match, hunt_expired;
    logic [HW-1:0] hunt_cnt;
    logic [7:0]  byte_cnt;

    // Decoder lines float while disabled; force them to "no data, no lock".
    assign dout_s = dec_enable & dec_dout;
    assign err_s  = ~dec_enable | dec_error;

    assign run       = state inside {ST_LOCK, ST_SYNC, ST_LEN, ST_PAYLOAD};
    assign clear_cnt = !(state inside {ST_LEN, ST_PAYLOAD});
    assign shift_en  = (state inside {ST_LEN, ST_PAYLOAD}) && !err_s && !abort;

    miller_rx_ctrl_deser u_deser (
        .clk2x      (clk2x),
        .rst_n      (rst_n),
        .run        (run),
        .clear_cnt  (clear_cnt),
        .shift_en   (shift_en),
        .din        (dout_s),
        .strobe     (strobe),
        .byte_data  (des_byte),
        .byte_ready (byte_ready)
    );

    // A match only counts once SW_BITS real bits have been shifted in.
    assign sync_bit     = strobe && (state == ST_SYNC) && !err_s;
    assign sreg_next    = (sreg << 1) | 16'(dout_s);
    assign sw_match     = (((sreg_next ^ SYNC_WORD) & SW_MASK) == 16'd0)
                          && (int'(hunt_cnt) >= SW_BITS - 1);
    assign hunt_expired = (hunt_cnt == HW'(HUNT_TIMEOUT - 1));

    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned.
        state_next = state;
        err_next   = ERR_NONE;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (start) state_next = ST_LOCK;
                ST_LOCK: if (!err_s && lock_prev) state_next = ST_SYNC;
                ST_SYNC: begin
                    if (err_s) begin
                        state_next = ST_ERR;
                        err_next   = ERR_SYNC_LOST;
                    end else if (sync_bit && sw_match) begin
                        state_next = ST_LEN;
                    end else if (sync_bit && hunt_expired) begin
                        state_next = ST_ERR;
                        err_next   = ERR_HUNT_TIMEOUT;
                    end
                end
                ST_LEN: begin
                    if (err_s) begin
                        state_next = ST_ERR;
                        err_next   = ERR_SYNC_LOST;
                    end else if (byte_ready) begin
                        if (des_byte == 8'd0) begin
                            state_next = ST_DONE;
                        end else if (des_byte > 8'(MAX_LEN)) begin
                            state_next = ST_ERR;
                            err_next   = ERR_BAD_LEN;
                        end else begin
                            state_next = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (err_s) begin
                        state_next = ST_ERR;
                        err_next   = ERR_SYNC_LOST;
                    end else if (byte_ready && (byte_cnt + 8'd1 == frame_len)) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE, ST_ERR: state_next = ST_IDLE;
                default:         state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dec_enable = (state != ST_IDLE);
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE) && !abort;
        frame_err  = (state == ST_ERR) && !abort;
        byte_valid = (state == ST_PAYLOAD) && byte_ready;
    end

    assign byte_data = des_byte;

    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            lock_prev <= 1'b0;
            sreg      <= '0;
            hunt_cnt  <= '0;
            byte_cnt  <= '0;
            frame_len <= '0;
            err_code  <= ERR_NONE;
        end else begin
            lock_prev <= (state == ST_LOCK) && !err_s;

            if (state == ST_SYNC) begin
                if (sync_bit) begin
                    sreg <= sreg_next;
                    if (hunt_cnt != HW'(HUNT_TIMEOUT)) hunt_cnt <= hunt_cnt + 1'b1;
                end
            end else begin
                sreg     <= '0;
                hunt_cnt <= '0;
            end

            if (state != ST_PAYLOAD)  byte_cnt <= '0;
            else if (byte_ready)      byte_cnt <= byte_cnt + 8'd1;

            if ((state == ST_IDLE) && start && !abort) begin
                frame_len <= '0;
                err_code  <= ERR_NONE;
            end else begin
                if ((state == ST_LEN) && byte_ready) frame_len <= des_byte;
                if (err_next != ERR_NONE)           err_code  <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_miller_rx_ctrl.sv
// Directed bench for miller_rx_ctrl: good frame, hunt timeout, bad length,
// sync loss, zero length, abort and mid-frame reset with floating decoder lines.
module tb_miller_rx_ctrl;

    logic       clk2x = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dec_dout;
    logic       dec_error;
    logic       dec_enable;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int done_cnt = 0;
    int err_cnt  = 0;

    miller_rx_ctrl dut (
        .clk2x      (clk2x),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .dec_dout   (dec_dout),
        .dec_error  (dec_error),
        .dec_enable (dec_enable),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk2x = ~clk2x;

    // Strobe monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk2x) begin
        if (byte_valid === 1'b1) rx_q.push_back(byte_data);
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1)  err_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk2x);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each bit spans a phase-0 and a phase-1 cycle; it is sampled on the second edge.
    task automatic send_bit(input logic b);
        dec_dout = b;
        step();
        step();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    // Start pulse, then two clean LOCK cycles; returns at the first SYNC cycle.
    task automatic arm();
        dec_error = 1'b0;
        dec_dout  = 1'b0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        step();
        step();
    endtask

    task automatic float_bus();
        dec_dout  = 1'bz;
        dec_error = 1'bz;
    endtask

    function automatic logic [31:0] all_outs();
        return {9'd0, dec_enable, busy, byte_valid, frame_done, frame_err,
                err_code, frame_len, byte_data};
    endfunction

    initial begin
        int         n0, d0, e0;
        logic       b, prev;
        logic [7:0] v;

        float_bus();
        step();
        step();
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_float_outputs", all_outs(), 32'd0);

        // Good frame: length 3, bytes A5 3C FF; start while busy must be ignored.
        n0 = rx_q.size(); d0 = done_cnt; e0 = err_cnt;
        arm();
        chk("t1_dec_enable", 32'(dec_enable), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send_word(16'hD391);
        send_byte(8'h03);
        chk("t1_frame_len", 32'(frame_len), 32'h03);
        send_byte(8'hA5);
        v = 8'h3C;
        start = 1'b1;
        send_bit(v[7]);
        start = 1'b0;
        for (int i = 6; i >= 0; i--) send_bit(v[i]);
        chk("t1_start_ignored_len", 32'(frame_len), 32'h03);
        v = 8'hFF;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        dec_dout = v[0];
        step();
        chk("t1_last_byte_valid", 32'(byte_valid), 32'd1);
        chk("t1_last_byte_data", 32'(byte_data), 32'hFF);
        step();
        chk("t1_frame_done", 32'(frame_done), 32'd1);
        chk("t1_err_code", 32'(err_code), 32'd0);
        float_bus();
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_dec_enable", 32'(dec_enable), 32'd0);
        chk("t1_byte_count", 32'(rx_q.size() - n0), 32'd3);
        if (rx_q.size() - n0 == 3) begin
            chk("t1_byte0", 32'(rx_q[n0]), 32'hA5);
            chk("t1_byte1", 32'(rx_q[n0 + 1]), 32'h3C);
            chk("t1_byte2", 32'(rx_q[n0 + 2]), 32'hFF);
        end
        chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t1_err_count", 32'(err_cnt - e0), 32'd0);

        // Hunt timeout: 1024 bits without "11" can never contain D391.
        n0 = rx_q.size(); e0 = err_cnt;
        arm();
        chk("t2_frame_len_cleared", 32'(frame_len), 32'd0);
        prev = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            b = prev ? 1'b0 : 1'($urandom_range(1, 0));
            send_bit(b);
            prev = b;
        end
        chk("t2_not_early", 32'(frame_err), 32'd0);
        send_bit(1'b0);
        chk("t2_frame_err", 32'(frame_err), 32'd1);
        chk("t2_err_code", 32'(err_code), 32'd2);
        float_bus();
        step();
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_err_code_held", 32'(err_code), 32'd2);
        chk("t2_err_count", 32'(err_cnt - e0), 32'd1);
        chk("t2_no_bytes", 32'(rx_q.size() - n0), 32'd0);

        // Length above MAX_LEN.
        n0 = rx_q.size();
        arm();
        chk("t3_err_code_cleared", 32'(err_code), 32'd0);
        send_word(16'hD391);
        send_byte(8'h41);
        chk("t3_frame_err", 32'(frame_err), 32'd1);
        chk("t3_err_code", 32'(err_code), 32'd3);
        chk("t3_frame_len", 32'(frame_len), 32'h41);
        float_bus();
        step();
        chk("t3_busy_after", 32'(busy), 32'd0);
        chk("t3_no_bytes", 32'(rx_q.size() - n0), 32'd0);

        // Sync loss on the sampling cycle of the 8th bit of the second byte.
        n0 = rx_q.size(); e0 = err_cnt;
        arm();
        send_word(16'hD391);
        send_byte(8'h02);
        send_byte(8'hA5);
        v = 8'h3C;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        dec_dout = v[0];
        step();
        dec_error = 1'b1;
        #1;
        chk("t4_bit_discarded", 32'(byte_valid), 32'd0);
        step();
        chk("t4_frame_err", 32'(frame_err), 32'd1);
        chk("t4_err_code", 32'(err_code), 32'd1);
        float_bus();
        step();
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_byte_count", 32'(rx_q.size() - n0), 32'd1);
        if (rx_q.size() - n0 == 1) chk("t4_byte0", 32'(rx_q[n0]), 32'hA5);
        chk("t4_err_count", 32'(err_cnt - e0), 32'd1);

        // Zero length completes straight after the length byte.
        n0 = rx_q.size(); d0 = done_cnt;
        arm();
        send_word(16'hD391);
        send_byte(8'h00);
        chk("t5_len0_done", 32'(frame_done), 32'd1);
        float_bus();
        step();
        chk("t5_len0_busy", 32'(busy), 32'd0);
        chk("t5_len0_no_bytes", 32'(rx_q.size() - n0), 32'd0);
        chk("t5_len0_done_count", 32'(done_cnt - d0), 32'd1);

        // Abort on the cycle a byte would complete: no strobe of any kind.
        n0 = rx_q.size(); d0 = done_cnt; e0 = err_cnt;
        arm();
        send_word(16'hD391);
        send_byte(8'h03);
        send_byte(8'hA5);
        v = 8'h3C;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        dec_dout = v[0];
        step();
        abort = 1'b1;
        #1;
        chk("t5_abort_byte_valid", 32'(byte_valid), 32'd0);
        step();
        abort = 1'b0;
        float_bus();
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_dec_enable", 32'(dec_enable), 32'd0);
        step();
        step();
        chk("t5_abort_bytes", 32'(rx_q.size() - n0), 32'd1);
        chk("t5_abort_no_status", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_start_abort_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-payload with floating decoder lines.
        arm();
        send_word(16'hD391);
        send_byte(8'h03);
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #3;
        rst_n = 1'b0;
        float_bus();
        #1;
        chk("t6_async_reset_outputs", all_outs(), 32'd0);
        step();
        chk("t6_reset_held_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        step();
        chk("t6_after_release", all_outs(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
